// File: rtl/nibble_serial_adder_ctrl.sv
`timescale 1ns/1ps
// nibble_serial_adder_ctrl
// Adds two W-bit two's-complement operands over NIBBLES cycles. One 4-bit
// ripple-carry adder built from full_adder cells is reused once per nibble,
// LSB first, and a registered carry links the nibbles.
// Optional feature: define ADDER_SUB_EN to add the `sub` port (A - B).

// Single-bit full adder cell; four of these form the shared nibble adder.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// state | meaning
// IDLE  | waiting for start
// RUN   | one nibble per cycle, nibble index in idx_q
// DONE  | result published, done pulse; start accepted again here
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
`ifdef ADDER_SUB_EN
  input  logic                 sub,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 v
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  shadow_q, shadow_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          v_q, v_d;
  logic          carry_init;

  logic [3:0]    nib_a, nib_b, nib_s;
  logic [4:0]    nib_c;

  assign nib_a = a_q[{idx_q, 2'b00} +: 4];

`ifdef ADDER_SUB_EN
  logic sub_q, sub_d;
  // Subtraction is A + ~B + 1: invert the B nibble and seed the carry with 1.
  assign nib_b      = b_q[{idx_q, 2'b00} +: 4] ^ {4{sub_q}};
  assign carry_init = sub;
`else
  assign nib_b      = b_q[{idx_q, 2'b00} +: 4];
  assign carry_init = 1'b0;
`endif

  assign nib_c[0] = carry_q;

  for (genvar g = 0; g < 4; g++) begin : g_fa
    full_adder u_fa (
      .a_i (nib_a[g]),
      .b_i (nib_b[g]),
      .c_i (nib_c[g]),
      .s_o (nib_s[g]),
      .c_o (nib_c[g+1])
    );
  end

  // Next-state logic: operand capture, nibble commit and result publish.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    shadow_d = shadow_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    v_d      = v_q;
`ifdef ADDER_SUB_EN
    sub_d    = sub_q;
`endif
    case (state_q)
      S_RUN: begin
        shadow_d[{idx_q, 2'b00} +: 4] = nib_s;
        carry_d = nib_c[4];
        if (idx_q == LAST) begin
          // Last nibble: publish the shadow including this nibble's result.
          sum_d   = shadow_d;
          cout_d  = nib_c[4];
          v_d     = nib_c[3] ^ nib_c[4];
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        // IDLE and DONE behave identically towards start.
        state_d = S_IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          carry_d = carry_init;
          state_d = S_RUN;
`ifdef ADDER_SUB_EN
          sub_d   = sub;
`endif
        end
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      v_q      <= 1'b0;
`ifdef ADDER_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      shadow_q <= shadow_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      v_q      <= v_d;
`ifdef ADDER_SUB_EN
      sub_q    <= sub_d;
`endif
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign v    = v_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
`timescale 1ns/1ps
// Bench for nibble_serial_adder_ctrl: directed cases with literal results,
// then random traffic checked every cycle against a transaction-level model.
module tb_nibble_serial_adder_ctrl;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;
`ifdef ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         sub_drv;
  logic         busy, done, cout, v;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef ADDER_SUB_EN
    .sub   (sub_drv),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .v     (v)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Result of one operation from signed/unsigned integer arithmetic: {v, cout, sum}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s);
    longint ux, uy, sx, sy, sres;
    logic [W-1:0] r;
    logic c, ov;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      sres = sx - sy;
      c    = (ux >= uy);
      r    = W'(ux - uy);
    end else begin
      sres = sx + sy;
      c    = ((ux + uy) >= (longint'(1) << W));
      r    = W'(ux + uy);
    end
    ov = (sres > ((longint'(1) << (W - 1)) - 1)) || (sres < -(longint'(1) << (W - 1)));
    return {ov, c, r};
  endfunction

  // Transaction model: an accepted op completes NIBBLES edges later.
  logic [W-1:0] m_sum;
  logic         m_cout, m_v, m_busy, m_done;
  logic [W+1:0] m_pend;
  int           m_rem;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_v    <= 1'b0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_pend <= '0;
      m_rem  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_rem != 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          {m_v, m_cout, m_sum} <= m_pend;
        end
      end else if (start) begin
        m_rem  <= NIBBLES;
        m_busy <= 1'b1;
        m_pend <= ref_op(a, b, sub_drv & SUB_EN);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cyc_busy", 32'(busy), 32'(m_busy));
    check("cyc_done", 32'(done), 32'(m_done));
    check("cyc_sum",  32'(sum),  32'(m_sum));
    check("cyc_cout", 32'(cout), 32'(m_cout));
    check("cyc_v",    32'(v),    32'(m_v));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xs, input logic [W-1:0] es, input logic ec, input logic ev);
    int lat, bcnt;
    bit seen;
    a = xa; b = xb; sub_drv = xs; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0; bcnt = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1;
      else if (busy) bcnt++;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat - 1), 32'(NIBBLES));
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(NIBBLES));
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_v"}, 32'(v), 32'(ev));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the end of the run");
    $fatal(1);
  end

  initial begin
    int nd;
    int d_idx[2];
    logic [W-1:0] d_sum[2];
    logic [W-1:0] s_seen;
    logic [W-1:0] corners[6];
    corners[0] = 16'h0000; corners[1] = 16'hFFFF; corners[2] = 16'h7FFF;
    corners[3] = 16'h8000; corners[4] = 16'h0001; corners[5] = 16'h8001;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub_drv = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_v",    32'(v),    32'd0);
    rst_n = 1'b1;
    tick();

    run_op("ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("minmin", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Start re-pulsed during the second RUN cycle must be ignored.
    a = 16'h1234; b = 16'h1111; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    nd = 0; s_seen = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin nd++; s_seen = sum; end
    end
    check("ignore_done_count", 32'(nd), 32'd1);
    check("ignore_sum", 32'(s_seen), 32'h2345);
    tick();

    // Back-to-back: start held, second op accepted in the DONE cycle, so
    // NIBBLES RUN cycles separate the two done pulses.
    a = 16'h00FF; b = 16'h0001; start = 1'b1;
    tick();
    a = 16'h0F0F; b = 16'h0101;
    nd = 0; d_idx[0] = 0; d_idx[1] = 0; d_sum[0] = '0; d_sum[1] = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (done && nd < 2) begin d_idx[nd] = i; d_sum[nd] = sum; nd++; end
      tick();
      if (nd >= 1) start = 1'b0;
    end
    check("b2b_done_count", 32'(nd), 32'd2);
    check("b2b_gap", 32'(d_idx[1] - d_idx[0]), 32'(NIBBLES + 1));
    check("b2b_sum0", 32'(d_sum[0]), 32'h0100);
    check("b2b_sum1", 32'(d_sum[1]), 32'h1010);

    // Reset during the third RUN cycle aborts the op.
    a = 16'h1234; b = 16'h1111; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum",  32'(sum),  32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_v",    32'(v),    32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", 32'(nd), 32'd0);
    tick();
    run_op("after_rst", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);

`ifdef ADDER_SUB_EN
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

    // Random traffic; the every-cycle compare does the checking.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) a = corners[$urandom_range(0, 5)];
      else a = W'($urandom);
      if ($urandom_range(0, 3) == 0) b = corners[$urandom_range(0, 5)];
      else b = W'($urandom);
      sub_drv = 1'($urandom) & SUB_EN;
      start   = ($urandom_range(0, 2) != 0);
      tick();
    end
    start = 1'b0;
    repeat (NIBBLES + 3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
